// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline sequencer for the five-stage core.
//
// Merges per-stage stall requests into the shared stall vector, sequences
// exception flushes with redirect-PC selection, counts stalled cycles and
// optionally runs a stall watchdog.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests
//   excepttype[31:0]    exception code from mem stage, 0 = none, 0xe = ERET
//   cp0_epc[31:0]       return PC used on ERET
//   stall[5:0]          hold vector: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
//   flush               one-cycle pipeline flush
//   new_pc[31:0]        redirect target, 0 whenever flush=0
//   stall_cnt[31:0]     free-running count of cycles with stall!=0 (wraps)
//   wdog_timeout        sticky watchdog flag
//
// Optional feature: define PIPE_CTRL_WDOG_EN to build the stall watchdog.
// Without it wdog_timeout is tied low and WDOG_LIMIT has no effect.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic        wdog_timeout
);

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state_q, state_d;
  logic [5:0] stall_enc;
  logic       exc_take;

  // An exception is only accepted in RUN; in HOLD the code still belongs to
  // the instruction that was just flushed.
  assign exc_take = (state_q == RUN) && (excepttype != 32'h0);

  // Highest requesting stage wins: it and everything upstream hold.
  always_comb begin
    stall_enc = 6'b000000;
    if (stallreq_mem)     stall_enc = 6'b011111;
    else if (stallreq_ex) stall_enc = 6'b001111;
    else if (stallreq_id) stall_enc = 6'b000111;
    else if (stallreq_if) stall_enc = 6'b000011;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: HOLD lasts exactly one cycle after an accepted exception
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:     state_d = exc_take ? HOLD : RUN;
      HOLD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs are combinational so the pipeline registers react this cycle.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (!rst) begin
      if (exc_take) begin
        flush  = 1'b1;
        new_pc = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
      end else begin
        stall = stall_enc;
      end
    end
  end

  // Stall-cycle counter; the flush cycle drives stall=0 so it never counts.
  always_ff @(posedge clk) begin
    if (rst)                 stall_cnt <= 32'h0;
    else if (stall != 6'b0)  stall_cnt <= stall_cnt + 32'h1;
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_LIMIT);

  logic [WD_W-1:0] wd_cnt;

  // Counts consecutive stalled cycles; saturates at the limit. The flag is
  // set on the edge that completes the WDOG_LIMIT-th consecutive stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt       <= '0;
      wdog_timeout <= 1'b0;
    end else if (flush || stall == 6'b0) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_LIM)         wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt >= WD_LIM - 1'b1)  wdog_timeout <= 1'b1;
    end
  end
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int unsigned LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_if, rq_id, rq_ex, rq_mem;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc, stall_cnt;
  logic        wdog_timeout;

  int checks = 0;
  int passed = 0;

  // Reference model state: "previous cycle flushed", counters, watchdog.
  bit          m_masked;
  logic [31:0] m_cnt;
  int unsigned m_run;
  bit          m_to;

  pipe_ctrl #(.EXC_VECTOR(VEC), .WDOG_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(rq_if), .stallreq_id(rq_id),
    .stallreq_ex(rq_ex), .stallreq_mem(rq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cnt(stall_cnt), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Number of held stages = highest requesting stage index + 1.
  function automatic logic [5:0] enc();
    int n;
    n = rq_mem ? 5 : rq_ex ? 4 : rq_id ? 3 : rq_if ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic set_rq(input logic i, input logic d, input logic e, input logic m);
    rq_if = i; rq_id = d; rq_ex = e; rq_mem = m;
  endtask

  // One clock: check combinational outputs against the model, clock,
  // advance the model, check registered outputs.
  task automatic cyc();
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    #1;
    e_stall = 6'b0; e_flush = 1'b0; e_pc = 32'h0;
    if (!rst) begin
      if (!m_masked && excepttype != 0) begin
        e_flush = 1'b1;
        e_pc = (excepttype == 32'he) ? cp0_epc : VEC;
      end else e_stall = enc();
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("new_pc", new_pc, e_pc);
    @(posedge clk);
    if (rst) begin
      m_masked = 0; m_cnt = 0; m_run = 0; m_to = 0;
    end else begin
      m_masked = e_flush;
      if (e_stall != 0) m_cnt = m_cnt + 1;
      if (e_stall == 0) m_run = 0;
      else if (m_run < LIM) m_run++;
      if (m_run >= LIM) m_to = 1;
    end
    #1;
    chk("stall_cnt", stall_cnt, m_cnt);
`ifdef PIPE_CTRL_WDOG_EN
    chk("wdog", 32'(wdog_timeout), 32'(m_to));
`else
    chk("wdog_off", 32'(wdog_timeout), 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst = 1; set_rq(0, 0, 0, 0); excepttype = 0;
    cyc();
    rst = 0;
  endtask

  initial begin
    rst = 1; set_rq(1, 1, 1, 1); excepttype = 32'h8; cp0_epc = 32'h0;
    m_masked = 0; m_cnt = 0; m_run = 0; m_to = 0;
    @(posedge clk); #1;

    // 1. Reset with everything asserted
    cyc(); cyc();
    chk("rst_cnt", stall_cnt, 32'h0);
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_pc", new_pc, 32'h0);
    rst = 0; set_rq(0, 0, 0, 0); excepttype = 0;
    cyc();

    // 2. Priority encoding
    set_rq(1, 0, 0, 0); #1; chk("enc_if", 32'(stall), 32'h03); cyc();
    set_rq(1, 1, 0, 0); #1; chk("enc_id", 32'(stall), 32'h07); cyc();
    set_rq(1, 1, 1, 0); #1; chk("enc_ex", 32'(stall), 32'h0f); cyc();
    set_rq(1, 1, 1, 1); #1; chk("enc_mem", 32'(stall), 32'h1f); cyc();
    chk("cnt4", stall_cnt, 32'd4);

    // 3. Exception beats a simultaneous stall; HOLD restores stall
    set_rq(0, 0, 0, 1); excepttype = 32'h8; #1;
    chk("x_flush", 32'(flush), 32'h1);
    chk("x_stall", 32'(stall), 32'h0);
    chk("x_pc", new_pc, 32'h20);
    cyc();
    #1;
    chk("hold_flush", 32'(flush), 32'h0);
    chk("hold_stall", 32'(stall), 32'h1f);
    cyc();
    set_rq(0, 0, 0, 0); excepttype = 0; cyc();

    // 4. ERET redirect and back-to-back masking: flush 1,0,1
    excepttype = 32'he; cp0_epc = 32'h8000_0100; #1;
    chk("eret_pc", new_pc, 32'h8000_0100);
    chk("eret_f0", 32'(flush), 32'h1); cyc();
    #1; chk("eret_f1", 32'(flush), 32'h0); cyc();
    #1; chk("eret_f2", 32'(flush), 32'h1); cyc();
    excepttype = 0; cyc();

    // 5. Counter wrap
    #1;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFE;
    set_rq(0, 1, 0, 0);
    repeat (3) cyc();
    chk("wrap", stall_cnt, 32'h1);
    set_rq(0, 0, 0, 0); cyc();

    // 6. Watchdog
    do_reset();
    set_rq(0, 0, 1, 0);
    repeat (7) cyc();
    chk("wd7", 32'(wdog_timeout), 32'h0);
    cyc();
`ifdef PIPE_CTRL_WDOG_EN
    chk("wd8", 32'(wdog_timeout), 32'h1);
`else
    chk("wd8_off", 32'(wdog_timeout), 32'h0);
`endif
    set_rq(0, 0, 0, 0); cyc(); cyc();
`ifdef PIPE_CTRL_WDOG_EN
    chk("wd_sticky", 32'(wdog_timeout), 32'h1);
`else
    chk("wd_sticky_off", 32'(wdog_timeout), 32'h0);
`endif
    do_reset();
    set_rq(0, 0, 1, 0); repeat (5) cyc();
    set_rq(0, 0, 0, 0); cyc();
    set_rq(0, 0, 1, 0); repeat (7) cyc();
    chk("wd_restart7", 32'(wdog_timeout), 32'h0);
    cyc();
`ifdef PIPE_CTRL_WDOG_EN
    chk("wd_restart8", 32'(wdog_timeout), 32'h1);
`else
    chk("wd_restart8_off", 32'(wdog_timeout), 32'h0);
`endif
    set_rq(0, 0, 0, 0); do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_rq($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      // Long stall runs now and then so the watchdog can trip
      if (i % 100 >= 80) rq_ex = 1'b1;
      cp0_epc = $urandom;
      case ($urandom_range(0, 9))
        0:       excepttype = 32'he;
        1:       excepttype = 32'h8;
        2:       excepttype = $urandom;
        default: excepttype = 32'h0;
      endcase
      cyc();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
